rx_comma_deserializer: RTL and testbench
========================================

RX_COMMA_DESERIALIZER -- requirements
Module: rx_comma_deserializer

Interface
REQ-001 SHALL have parameter MISALIGN_MAX, default 3, meaning the count of consecutive misaligned commas that forces realignment (legal 1..15).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port serial_in  input  1  line bit; first-transmitted bit is 8b/10b bit 'a', MSB-first order.
REQ-005 SHALL have port serial_valid  input  1  serial_in is sampled only on edges where this is 1.
REQ-006 SHALL have port dout  output  10  recovered code group {a,b,c,d,e,i,f,g,h,j} at bits [9:0], first-received bit at [9].
REQ-007 SHALL have port dout_valid  output  1  one-cycle pulse marking a new dout.
REQ-008 SHALL have port is_comma  output  1  dout equals K28.5 (10'b0011111010 or 10'b1100000101); qualified by dout_valid.
REQ-009 SHALL have port locked  output  1  word alignment established.
REQ-010 SHALL have port realign  output  1  one-cycle pulse when lock is (re)acquired at a new phase.

Function
REQ-011 SHALL keep a 10-bit window; on each edge with serial_valid=1, window_next = {window[8:0], serial_in}, else window holds.
REQ-012 SHALL compare window_next against both K28.5 disparities each valid edge (comma_hit).
REQ-013 SHALL implement two states: HUNT (locked=0) and LOCK (locked=1).
REQ-014 SHALL keep a phase counter cnt 0..9 advancing by 1 per valid bit in LOCK, wrapping 9->0.
REQ-015 HUNT: on comma_hit, SHALL go to LOCK, set cnt=0, emit dout=window_next, dout_valid=1, is_comma=1, realign=1.
REQ-016 HUNT: without comma_hit, SHALL emit nothing (dout_valid=0).
REQ-017 LOCK, cnt==9 on a valid edge: SHALL emit dout=window_next, dout_valid=1, is_comma=comma_hit, and clear the misalign counter if comma_hit.
REQ-018 LOCK, comma_hit with cnt!=9: SHALL increment misalign counter; when the increment reaches MISALIGN_MAX, SHALL set cnt=0, emit the comma word (dout_valid=1, is_comma=1), pulse realign, clear the counter, stay in LOCK.
REQ-019 Misaligned comma below MISALIGN_MAX SHALL NOT emit a word and SHALL NOT disturb cnt.
REQ-020 Latency: dout/dout_valid SHALL update on the same edge that samples the 10th bit of the group (registered, visible the following cycle).
REQ-021 dout SHALL hold its last value when dout_valid=0; dout_valid, realign SHALL be 0 in any cycle without a qualifying event.
REQ-022 Edges with serial_valid=0 SHALL change no state and SHALL drive dout_valid=0, realign=0.
REQ-023 Misalign counter SHALL saturate-free: it never exceeds MISALIGN_MAX since reaching it triggers clear.

Reset
REQ-024 rst_n=0 SHALL asynchronously force window=0, cnt=0, misalign counter=0, state=HUNT, dout=0, dout_valid=0, is_comma=0, locked=0, realign=0.
REQ-025 Reset asserted mid-word SHALL discard partial bits; after release, the block SHALL re-hunt from an empty window.
REQ-026 First valid edge after rst_n rises SHALL be treated as bit 1 of the window; all-zero window SHALL NOT match a comma.

Verification
REQ-027 Reset, then 10 valid bits of 0011111010 -> dout=10'h0FA, dout_valid=1, is_comma=1, realign=1, locked=1 on the 10th edge.
REQ-028 Locked, then 10 bits of D21.5 (1010101010) -> one dout_valid pulse, dout=10'h2AA, is_comma=0; no pulse on intermediate edges.
REQ-029 Locked, insert 3 random bits then stream K28.5 (RD+) words at shifted phase, MISALIGN_MAX=3 -> first two misaligned commas give no output; third gives dout=10'h305, is_comma=1, realign=1; following words aligned to new phase.
REQ-030 serial_valid toggled 0/1 every cycle during a word -> identical dout sequence to continuous stream, only timing stretched.
REQ-031 rst_n pulled low at bit 5 of a locked word -> all outputs 0 immediately (async); after release, no dout_valid until a full comma received.
REQ-032 Back-to-back K28.5 RD-/RD+ at aligned phase -> misalign counter stays 0, is_comma=1 on each pulse, realign only on the initial acquisition.

Source files
------------

// File: rtl/rx_comma_deserializer_if.sv
// Serial-in / recovered-word-out bundle for the comma deserializer.
// The master drives the line side, the slave (the deserializer) drives the word side.
interface rx_comma_deserializer_if;
  logic       serial_in;
  logic       serial_valid;
  logic [9:0] dout;
  logic       dout_valid;
  logic       is_comma;
  logic       locked;
  logic       realign;

  modport master (
    output serial_in,
    output serial_valid,
    input  dout,
    input  dout_valid,
    input  is_comma,
    input  locked,
    input  realign
  );

  modport slave (
    input  serial_in,
    input  serial_valid,
    output dout,
    output dout_valid,
    output is_comma,
    output locked,
    output realign
  );
endinterface

// File: rtl/rx_comma_deserializer.sv
// K28.5-aligned 10-bit deserializer with HUNT/LOCK word alignment.
// dout is registered on the edge that samples a group's 10th bit; no backpressure, a word is presented once.
module rx_comma_deserializer #(
  parameter int unsigned MISALIGN_MAX = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rx_comma_deserializer_if.slave rx
);

  if (MISALIGN_MAX < 1 || MISALIGN_MAX > 15) begin : g_bad_param
    $error("MISALIGN_MAX must be in 1..15");
  end

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;
  localparam logic [3:0] MIS_MAX   = 4'(MISALIGN_MAX);
  localparam logic [3:0] CNT_LAST  = 4'd9;

  state_t     state_q,      state_d;
  logic [9:0] window_q,     window_d;
  logic [3:0] cnt_q,        cnt_d;
  logic [3:0] mis_q,        mis_d;
  logic [9:0] dout_q,       dout_d;
  logic       dout_valid_q, dout_valid_d;
  logic       is_comma_q,   is_comma_d;
  logic       realign_q,    realign_d;

  logic [9:0] win_next;
  logic       comma_hit;
  logic [3:0] mis_inc;

  assign win_next  = {window_q[8:0], rx.serial_in};
  assign comma_hit = (win_next == K28_5_RDN) || (win_next == K28_5_RDP);
  assign mis_inc   = mis_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    window_d     = window_q;
    cnt_d        = cnt_q;
    mis_d        = mis_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    is_comma_d   = is_comma_q;
    realign_d    = 1'b0;

    if (rx.serial_valid) begin
      window_d = win_next;
      unique case (state_q)
        HUNT: begin
          if (comma_hit) begin
            state_d      = LOCK;
            cnt_d        = '0;
            mis_d        = '0;
            dout_d       = win_next;
            dout_valid_d = 1'b1;
            is_comma_d   = 1'b1;
            realign_d    = 1'b1;
          end
        end
        LOCK: begin
          if (cnt_q == CNT_LAST) begin
            // Word boundary at the current phase; an aligned comma re-arms the misalign count.
            cnt_d        = '0;
            dout_d       = win_next;
            dout_valid_d = 1'b1;
            is_comma_d   = comma_hit;
            if (comma_hit) begin
              mis_d = '0;
            end
          end else if (comma_hit && (mis_inc == MIS_MAX)) begin
            // Enough commas at another phase: jump to it without leaving LOCK.
            cnt_d        = '0;
            mis_d        = '0;
            dout_d       = win_next;
            dout_valid_d = 1'b1;
            is_comma_d   = 1'b1;
            realign_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
            if (comma_hit) begin
              mis_d = mis_inc;
            end
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      window_q     <= '0;
      cnt_q        <= '0;
      mis_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      is_comma_q   <= 1'b0;
      realign_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      window_q     <= window_d;
      cnt_q        <= cnt_d;
      mis_q        <= mis_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      is_comma_q   <= is_comma_d;
      realign_q    <= realign_d;
    end
  end

  assign rx.dout       = dout_q;
  assign rx.dout_valid = dout_valid_q;
  assign rx.is_comma   = is_comma_q;
  assign rx.locked     = (state_q == LOCK);
  assign rx.realign    = realign_q;

endmodule

// File: tb/tb_rx_comma_deserializer.sv
// Directed bench for rx_comma_deserializer: vector table for acquisition and a data word,
// then hand-written sequences for phase shift, gapped input, async reset and back-to-back commas.
module tb_rx_comma_deserializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rx_comma_deserializer_if rx ();

  rx_comma_deserializer #(.MISALIGN_MAX(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx)
  );

  typedef struct {
    logic       sin;
    logic       sv;
    logic       dv;
    logic [9:0] dout;
    logic       ic;
    logic       lk;
    logic       ra;
  } vec_t;

  vec_t vt[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic sin, input logic sv, input logic dv, input logic [9:0] d,
                     input logic ic, input logic lk, input logic ra);
    vec_t v;
    v.sin = sin; v.sv = sv; v.dv = dv; v.dout = d; v.ic = ic; v.lk = lk; v.ra = ra;
    vt.push_back(v);
  endtask

  task automatic drive(input logic b, input logic v);
    @(negedge clk);
    rx.serial_in    = b;
    rx.serial_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic bit_chk(input string tag, input logic b, input logic v,
                         input logic edv, input logic era);
    drive(b, v);
    chk({tag, "_dv"}, 32'(rx.dout_valid), 32'(edv));
    chk({tag, "_realign"}, 32'(rx.realign), 32'(era));
  endtask

  task automatic word_chk(input string tag, input logic [9:0] d, input logic ic);
    chk({tag, "_dout"}, 32'(rx.dout), 32'(d));
    chk({tag, "_is_comma"}, 32'(rx.is_comma), 32'(ic));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] w;
    logic       edv, era;
    string      tag;

    rx.serial_in    = 1'b0;
    rx.serial_valid = 1'b0;

    // Acquisition from reset, an idle edge, then one aligned data word.
    w = 10'h0FA;
    for (int i = 0; i < 10; i++)
      add(w[9-i], 1'b1, i == 9, (i == 9) ? 10'h0FA : 10'h000, i == 9, i == 9, i == 9);
    add(1'b1, 1'b0, 1'b0, 10'h0FA, 1'b1, 1'b1, 1'b0);
    w = 10'h2AA;
    for (int i = 0; i < 10; i++)
      add(w[9-i], 1'b1, i == 9, (i == 9) ? 10'h2AA : 10'h0FA, i != 9, 1'b1, 1'b0);

    #1;
    chk("rst_dout", 32'(rx.dout), 32'h0);
    chk("rst_dv", 32'(rx.dout_valid), 32'h0);
    chk("rst_is_comma", 32'(rx.is_comma), 32'h0);
    chk("rst_locked", 32'(rx.locked), 32'h0);
    chk("rst_realign", 32'(rx.realign), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[k]) begin
      drive(vt[k].sin, vt[k].sv);
      chk($sformatf("vec%0d_dv", k), 32'(rx.dout_valid), 32'(vt[k].dv));
      chk($sformatf("vec%0d_dout", k), 32'(rx.dout), 32'(vt[k].dout));
      chk($sformatf("vec%0d_is_comma", k), 32'(rx.is_comma), 32'(vt[k].ic));
      chk($sformatf("vec%0d_locked", k), 32'(rx.locked), 32'(vt[k].lk));
      chk($sformatf("vec%0d_realign", k), 32'(rx.realign), 32'(vt[k].ra));
    end

    // Phase slip by 3 bits, then RD+ commas: two ignored, the third realigns.
    w = 10'b0000000010;
    for (int i = 7; i < 10; i++) bit_chk("slip_pad", w[9-i], 1'b1, 1'b0, 1'b0);
    w = 10'h305;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 10; i++) begin
        tag = $sformatf("slip_c%0d_b%0d", k, i);
        edv = (i == 6) || (k == 2 && i == 9);
        era = (k == 2 && i == 9);
        bit_chk(tag, w[9-i], 1'b1, edv, era);
        if (i == 6) word_chk(tag, (k == 0) ? 10'h160 : 10'h2E0, 1'b0);
        if (k == 2 && i == 9) begin
          word_chk(tag, 10'h305, 1'b1);
          chk({tag, "_locked"}, 32'(rx.locked), 32'h1);
        end
      end
    end
    for (int i = 0; i < 10; i++) bit_chk($sformatf("newphase_b%0d", i), w[9-i], 1'b1, i == 9, 1'b0);
    word_chk("newphase", 10'h305, 1'b1);

    // Back-to-back commas of alternating disparity at the aligned phase.
    for (int k = 0; k < 3; k++) begin
      w = (k == 1) ? 10'h305 : 10'h0FA;
      for (int i = 0; i < 10; i++) bit_chk($sformatf("b2b%0d_b%0d", k, i), w[9-i], 1'b1, i == 9, 1'b0);
      word_chk($sformatf("b2b%0d", k), w, 1'b1);
    end

    // Gapped input: every valid bit is preceded by an invalid edge carrying junk.
    for (int k = 0; k < 2; k++) begin
      w = (k == 0) ? 10'h2AA : 10'h305;
      for (int i = 0; i < 10; i++) begin
        bit_chk($sformatf("gap%0d_idle%0d", k, i), ~w[9-i], 1'b0, 1'b0, 1'b0);
        bit_chk($sformatf("gap%0d_b%0d", k, i), w[9-i], 1'b1, i == 9, 1'b0);
      end
      word_chk($sformatf("gap%0d", k), w, k == 1);
    end
    chk("gap_locked", 32'(rx.locked), 32'h1);

    // Asynchronous reset in the middle of a locked word.
    w = 10'h2AA;
    for (int i = 0; i < 5; i++) bit_chk($sformatf("midrst_b%0d", i), w[9-i], 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_dout", 32'(rx.dout), 32'h0);
    chk("async_rst_is_comma", 32'(rx.is_comma), 32'h0);
    chk("async_rst_locked", 32'(rx.locked), 32'h0);
    chk("async_rst_dv", 32'(rx.dout_valid), 32'h0);
    chk("async_rst_realign", 32'(rx.realign), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bit_chk($sformatf("rehunt_b%0d", i), w[9-i], 1'b1, 1'b0, 1'b0);
      chk($sformatf("rehunt_b%0d_locked", i), 32'(rx.locked), 32'h0);
    end
    w = 10'h0FA;
    for (int i = 0; i < 10; i++) bit_chk($sformatf("reacq_b%0d", i), w[9-i], 1'b1, i == 9, i == 9);
    word_chk("reacq", 10'h0FA, 1'b1);
    chk("reacq_locked", 32'(rx.locked), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
